// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the iterative ALU: mode select values, arithmetic and
// logic opcode encodings, the control FSM state encoding and the packed
// comparison-flag bundle that travels with each result.
// -----------------------------------------------------------------------------
package alu_pkg;

    // mode input
    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // Arithmetic opcodes (mode 0)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    // Logic opcodes (mode 1)
    localparam logic [2:0] LOP_AND  = 3'b000;
    localparam logic [2:0] LOP_OR   = 3'b001;
    localparam logic [2:0] LOP_XOR  = 3'b010;
    localparam logic [2:0] LOP_NOT  = 3'b011;
    localparam logic [2:0] LOP_SHL  = 3'b100;
    localparam logic [2:0] LOP_SHR  = 3'b101;
    localparam logic [2:0] LOP_PASS = 3'b110;
    localparam logic [2:0] LOP_NAND = 3'b111;

    // Control FSM
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Operand comparison flags, captured when an operation is accepted
    typedef struct packed {
        logic za;
        logic zb;
        logic eq;
        logic gt;
        logic lt;
    } flags_t;

endpackage

// File: rtl/alu_muldiv_core.sv
// -----------------------------------------------------------------------------
// alu_muldiv_core
// Iterative unsigned multiply (shift-add) and restoring divide sharing one
// 2*WIDTH accumulator, one operand register and one iteration counter.
//
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   start_i     load operands and clear the counter (one cycle)
//   div_i       with start_i: 1 = divide, 0 = multiply
//   step_i      perform one iteration this cycle
//   a_i, b_i    operands (multiplicand/multiplier or dividend/divisor)
//   done_o      high during the final iteration
//   result_o    accumulator value after this cycle's iteration; valid as the
//               final result when done_o is high
//                 multiply: a*b        divide: {a%b, a/b}
// -----------------------------------------------------------------------------
module alu_muldiv_core #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               div_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2*WIDTH-1:0] step_val;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;

    // Multiply: acc = {partial product, remaining multiplier bits}. Add the
    // multiplicand into the upper half when the multiplier LSB is set, then
    // shift the whole thing (including the add carry) right by one.
    assign addend  = acc_q[0] ? opnd_q : '0;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // Divide: acc = {partial remainder, dividend/quotient}. Shift left one,
    // try subtracting the divisor from the remainder; keep the difference and
    // shift in a 1 when it does not go negative. The remainder is always below
    // the divisor, so the shifted remainder fits in WIDTH+1 bits and trial's
    // MSB is the borrow.
    assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, opnd_q};

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        step_val = acc_q;
        if (div_q) begin
            if (trial[WIDTH]) begin
                step_val = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                step_val = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_val = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i) begin
            // Multiplier (b) or dividend (a) goes into the low half.
            acc_d = {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
            cnt_d = '0;
        end else if (step_i) begin
            acc_d = step_val;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (start_i) begin
                opnd_q <= div_i ? b_i : a_i;
                div_q  <= div_i;
            end
        end
    end

    // The counter reaches WIDTH on the same edge as the last iteration.
    assign done_o   = step_i && (cnt_q == CNT_W'(WIDTH - 1));
    assign result_o = step_val;

endmodule

// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
// WIDTH-bit ALU with valid/ready handshakes. Logic, add/sub, inc/dec and
// compare finish in one cycle; multiply and divide iterate WIDTH cycles in
// alu_muldiv_core. Results and flags are held until the consumer accepts them.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   in_valid, in_ready    input handshake (accept = in_valid & in_ready)
//   a, b                  unsigned operands
//   mode, opcode          0 = arithmetic, 1 = logic; operation select
//   out_valid, out_ready  output handshake
//   out_alu               2*WIDTH result
//   za, zb, eq, gt, lt    operand comparison flags of the held result
//   zr                    out_alu == 0
//   err                   divide by zero
// -----------------------------------------------------------------------------
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    input  logic [2:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_alu,
    output logic               za,
    output logic               zb,
    output logic               eq,
    output logic               gt,
    output logic               lt,
    output logic               zr,
    output logic               err
);

    state_t state_q, state_d;

    logic               accept;
    logic               is_mul, is_div, div_by_zero, iter_op;
    logic               step, core_done;
    logic [2*WIDTH-1:0] core_result;

    logic [2*WIDTH-1:0] out_alu_q;
    flags_t             flags_q, flags_pend_q, in_flags;
    logic               zr_q, err_q;

    // ------------------------------------------------------------------
    // Handshake and operation classification
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    assign is_mul      = (mode == MODE_ARITH) && (opcode == OP_MUL);
    assign div_by_zero = (mode == MODE_ARITH) && (opcode == OP_DIV) && (b == '0);
    // Divide by zero needs no iterations and completes like a single-cycle op.
    assign is_div      = (mode == MODE_ARITH) && (opcode == OP_DIV) && (b != '0);
    assign iter_op     = is_mul || is_div;

    assign in_flags = '{za: (a == '0), zb: (b == '0), eq: (a == b),
                        gt: (a > b),   lt: (a < b)};

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]       add_w, sub_w;
    logic [WIDTH-1:0]     inc_w, dec_w, shl_w, shr_w;
    logic [CNT_W-1:0]     shamt;
    logic                 shift_oob;
    logic [2*WIDTH-1:0]   single_res;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};   // MSB is the borrow (a < b)
    assign inc_w = a + 1'b1;
    assign dec_w = a - 1'b1;

    assign shamt     = b[CNT_W-1:0];
    assign shift_oob = (shamt >= CNT_W'(WIDTH));
    assign shl_w     = shift_oob ? '0 : (a << shamt);
    assign shr_w     = shift_oob ? '0 : (a >> shamt);

    always_comb begin
        single_res = '0;
        if (mode == MODE_ARITH) begin
            case (opcode)
                OP_ADD:  single_res = {{(WIDTH-1){1'b0}}, add_w};
                OP_SUB:  single_res = {{(WIDTH-1){1'b0}}, sub_w};
                OP_DIV:  single_res = {a, {WIDTH{1'b1}}};  // b == 0 only
                OP_INC:  single_res = {{WIDTH{1'b0}}, inc_w};
                OP_DEC:  single_res = {{WIDTH{1'b0}}, dec_w};
                default: single_res = '0;                  // MUL, CMP, reserved
            endcase
        end else begin
            case (opcode)
                LOP_AND:  single_res = {{WIDTH{1'b0}}, a & b};
                LOP_OR:   single_res = {{WIDTH{1'b0}}, a | b};
                LOP_XOR:  single_res = {{WIDTH{1'b0}}, a ^ b};
                LOP_NOT:  single_res = {{WIDTH{1'b0}}, ~a};
                LOP_SHL:  single_res = {{WIDTH{1'b0}}, shl_w};
                LOP_SHR:  single_res = {{WIDTH{1'b0}}, shr_w};
                LOP_PASS: single_res = {{WIDTH{1'b0}}, a};
                default:  single_res = {{WIDTH{1'b0}}, ~(a & b)};
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Iterative multiply / divide
    // ------------------------------------------------------------------
    assign step = (state_q == MUL) || (state_q == DIV);

    alu_muldiv_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && iter_op),
        .div_i    (is_div),
        .step_i   (step),
        .a_i      (a),
        .b_i      (b),
        .done_o   (core_done),
        .result_o (core_result)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = MUL;
                    end else if (is_div) begin
                        state_d = DIV;
                    end else begin
                        state_d = DONE;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL, DIV: begin
                if (core_done) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: written only on entry to DONE. Iterative ops park
    // their accept-time flags in flags_pend_q until the core finishes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_alu_q    <= '0;
            flags_q      <= '0;
            flags_pend_q <= '0;
            zr_q         <= 1'b0;
            err_q        <= 1'b0;
        end else if (accept) begin
            err_q <= div_by_zero;
            if (iter_op) begin
                flags_pend_q <= in_flags;
            end else begin
                out_alu_q <= single_res;
                flags_q   <= in_flags;
                zr_q      <= (single_res == '0);
            end
        end else if (core_done) begin
            out_alu_q <= core_result;
            flags_q   <= flags_pend_q;
            zr_q      <= (core_result == '0);
        end
    end

    assign out_alu = out_alu_q;
    assign za      = flags_q.za;
    assign zb      = flags_q.zb;
    assign eq      = flags_q.eq;
    assign gt      = flags_q.gt;
    assign lt      = flags_q.lt;
    assign zr      = zr_q;
    assign err     = err_q;

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised successor to the 16-bit ALU: a WIDTH-bit ALU with a valid/ready handshake on both sides, single-cycle logic and add/sub operations, and iterative shift-add multiply and restoring divide. Sits between register-file read and writeback in the multi-cycle core. Holds results and comparison flags until the consumer accepts them.

## Interface
- WIDTH, 16: operand width; result is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived, do not override).

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept
- a, b  in  WIDTH  operands, unsigned
- mode  in  1  0 = arithmetic, 1 = logic
- opcode  in  3  operation select
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- out_alu  out  2*WIDTH  result
- za, zb, eq, gt, lt  out  1 each  a==0, b==0, a==b, a>b, a<b (unsigned), captured at accept
- zr  out  1  out_alu == 0
- err  out  1  divide by zero

## Operation
- Arithmetic (mode 0): 000 ADD: out = {0, carry, a+b}; 001 SUB: out = {0, borrow, a-b}, borrow = a<b; 010 MUL: unsigned a*b, full 2*WIDTH; 011 DIV: out = {a%b, a/b}; 100 INC a; 101 DEC a (wraps, no carry bit); 110 CMP: out = 0, flags only; 111 reserved: out = 0.
- Logic (mode 1): 000 AND; 001 OR; 010 XOR; 011 NOT a; 100 SHL a by b[CNT_W-1:0]; 101 SHR logical; 110 PASS a; 111 NAND. Logic results zero-extended to 2*WIDTH; shift amount >= WIDTH gives 0.
- Accept = in_valid & in_ready. in_ready = (state==IDLE) | (state==DONE & out_ready).
- FSM: IDLE -> DONE on accept of single-cycle op; IDLE -> MUL / DIV on accept of MUL / DIV; MUL/DIV -> DONE when counter reaches WIDTH; DONE -> IDLE on out_ready without new accept; DONE -> DONE/MUL/DIV on out_ready with simultaneous accept (back-to-back).
- MUL: per cycle, if multiplier LSB set add multiplicand to upper accumulator, shift right one; WIDTH iterations.
- DIV: restoring, one quotient bit per cycle, MSB first; WIDTH iterations. b==0: skip iteration, go straight to DONE with quotient = all ones, remainder = a, err = 1.
- Operands latched at accept; input changes while busy ignored.
- Outputs out_alu, flags, zr, err stable throughout DONE; updated only on transition into DONE.
- err cleared on next accept of any op.

## Timing
- Reset (async, immediate): state IDLE, in_ready 1, out_valid 0, out_alu 0, all flags 0, err 0, counter 0.
- Single-cycle ops: accept at edge k, out_valid high after edge k+1.
- MUL/DIV: accept at edge k, out_valid high after edge k+WIDTH+1. Divide by zero: after edge k+1.
- Throughput: one single-cycle op per clock when out_ready held high.
- out_valid deasserts on the edge where out_ready is sampled high, unless a new single-cycle op is accepted the same edge (stays high with new result).
- Reset mid-iteration: partial result discarded, no out_valid.

## Structure
- Package alu_pkg: mode constants, arithmetic/logic opcode localparams, FSM state encoding (IDLE, MUL, DIV, DONE).
- One sub-module: alu_muldiv_core (shared accumulator/shift register, counter, add/subtract step, done pulse); top holds FSM, single-cycle datapath, handshake, output registers.

## Test plan
- Reset: assert rst_n=0 mid-MUL -> in_ready=1, out_valid=0, out_alu=0, flags 0 immediately.
- ADD 0xFFFF+0x0001, WIDTH=16 -> out_alu=0x0001_0000, out_valid 1 cycle after accept, gt=1, zr=0.
- MUL 0xFFFF*0xFFFF -> out_alu=0xFFFE_0001, out_valid exactly 17 cycles after accept.
- DIV 100/7 -> out_alu=0x0002_000E; DIV 5/0 -> out_alu=0x0005_FFFF, err=1, latency 1.
- Backpressure: out_ready=0 for 5 cycles after result -> out_alu/out_valid stable, in_ready=0; release -> next op accepted same edge.
- Back-to-back: stream AND, OR, XOR, SHL(0x0001 by 17) with out_ready=1 -> one result per cycle, SHL result 0.
